// File: rtl/zx_pkg.sv
// Shared constants for the Z80 system slice: speed encodings, interrupt
// pulse default and a constant-evaluable clog2.
package zx_pkg;

  localparam logic [1:0] SPEED_1X = 2'd0;
  localparam logic [1:0] SPEED_2X = 2'd1;
  localparam logic [1:0] SPEED_4X = 2'd2;
  localparam logic [1:0] SPEED_8X = 2'd3;

  localparam int INT_LEN_DEF = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ce_gen.sv
// CPU phase-enable generator: free-running phase counter with latched speed
// and contention stretching of the last phase of a T-state.
module ce_gen
  import zx_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       contend,
  output logic       cep,
  output logic       cen,
  output logic [1:0] speed_l
);

  localparam int CW = clog2(DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] last;
  logic [CW-1:0] half_nxt;
  logic [1:0]    speed_nxt;
  logic          wrap;
  logic          stall;

  always_comb begin
    last      = CW'((DIV >> speed_l) - 1);
    wrap      = (cnt == last);
    stall     = wrap && contend;
    // Speed only changes at a T-state boundary, so the new period starts at 0.
    speed_nxt = (wrap && !stall) ? speed : speed_l;
    half_nxt  = CW'((DIV >> speed_nxt) >> 1);
    cnt_nxt   = cnt;
    if (!stall) cnt_nxt = wrap ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      cep     <= 1'b0;
      cen     <= 1'b0;
      speed_l <= SPEED_1X;
    end else begin
      cnt     <= cnt_nxt;
      speed_l <= speed_nxt;
      cep     <= wrap && !stall;
      // cen fires only on entry to the half point, so a stall never repeats it.
      cen     <= !stall && (cnt_nxt == half_nxt);
    end
  end

endmodule

// File: rtl/cpu_ctl.sv
// Z80 clock-enable, wait-state and frame-interrupt controller: wraps ce_gen
// and adds memory/I/O wait insertion plus a fixed-length int_n pulse.
module cpu_ctl
  import zx_pkg::*;
#(
  parameter int DIV      = 8,
  parameter int MEM_WAIT = 1,
  parameter int IO_WAIT  = 1,
  parameter int INT_LEN  = INT_LEN_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       contend,
  input  logic       intreq,
  input  logic       mreq,
  input  logic       iorq,
  input  logic       m1,
  output logic       cep,
  output logic       cen,
  output logic       wait_n,
  output logic       int_n
);

  logic [1:0] speed_l;
  logic       iorq_q;
  logic       mreq_q;
  logic       io_edge;
  logic       mem_edge;
  logic       ack;
  logic [3:0] wcnt;
  logic [3:0] wcnt_nxt;
  logic [7:0] icnt;
  logic [7:0] icnt_nxt;

  ce_gen #(.DIV(DIV)) u_ce_gen (
    .clock   (clock),
    .reset   (reset),
    .speed   (speed),
    .contend (contend),
    .cep     (cep),
    .cen     (cen),
    .speed_l (speed_l)
  );

  always_comb begin
    // Interrupt acknowledge (m1 low) is excluded from I/O waits.
    io_edge  = cen && iorq_q && !iorq && m1;
    mem_edge = cen && mreq_q && !mreq;
    ack      = cen && !m1 && !iorq;

    wcnt_nxt = wcnt;
    if (wcnt != 4'd0) begin
      if (cep) wcnt_nxt = wcnt - 4'd1;
    end else if (io_edge) begin
      wcnt_nxt = 4'(IO_WAIT);
    end else if (mem_edge) begin
      wcnt_nxt = (speed_l != SPEED_1X) ? 4'(MEM_WAIT) : 4'd0;
    end

    icnt_nxt = icnt;
    if (intreq)                   icnt_nxt = 8'(INT_LEN);
    else if (ack)                 icnt_nxt = 8'd0;
    else if (cep && icnt != 8'd0) icnt_nxt = icnt - 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iorq_q <= 1'b1;
      mreq_q <= 1'b1;
      wcnt   <= 4'd0;
      icnt   <= 8'd0;
      wait_n <= 1'b1;
      int_n  <= 1'b1;
    end else begin
      if (cen) begin
        iorq_q <= iorq;
        mreq_q <= mreq;
      end
      wcnt   <= wcnt_nxt;
      icnt   <= icnt_nxt;
      wait_n <= (wcnt_nxt == 4'd0);
      int_n  <= (icnt_nxt == 8'd0);
    end
  end

endmodule
